soc_mem_mp_arb: RTL and testbench

//  Multi-channel data memory for the SoC: NUM_CH requesters (core fetch, core LSU, debug/DMA)

---
 rtl/soc_mem_pkg.sv | 19 +
 rtl/soc_rr_arbiter.sv | 44 ++++
 rtl/soc_mem_mp_arb.sv | 117 +++++++++++
 tb/tb_soc_mem_mp_arb.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/soc_mem_pkg.sv
// Shared types and limits for the multi-channel SoC data memory.
package soc_mem_pkg;

    localparam int MAX_CH         = 8;
    localparam int MAX_RD_LATENCY = 4;
    // Pipe entries carry data at the widest supported word; the top truncates on output.
    localparam int MAX_DATA_WIDTH = 128;
    localparam int CH_ID_W        = $clog2(MAX_CH);

    typedef logic [CH_ID_W-1:0] ch_id_t;

    typedef struct packed {
        logic                      valid;
        ch_id_t                    ch_id;
        logic [MAX_DATA_WIDTH-1:0] data;
        logic                      err;
    } rd_pipe_t;

endpackage

// File: rtl/soc_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// and moves the pointer past the winner whenever a grant is consumed.
module soc_rr_arbiter
    import soc_mem_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant,
    output ch_id_t       grant_id
);

    ch_id_t ptr;
    logic   found;

    // Priority search over the rotated request vector; grant is one-hot or zero.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int c = 0; c < N; c++) begin
                if (!found && req[c] && ((int'(ptr) + i == c) || (int'(ptr) + i == c + N))) begin
                    found    = 1'b1;
                    grant[c] = 1'b1;
                    grant_id = ch_id_t'(c);
                end
            end
        end
    end

    // Pointer moves to the channel after the winner on each transfer; fixed at 0 for N=1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && (N > 1)) begin
            ptr <= (grant_id == ch_id_t'(N - 1)) ? '0 : grant_id + ch_id_t'(1);
        end
    end

endmodule

// File: rtl/soc_mem_mp_arb.sv
// Multi-channel data memory: NUM_CH requesters share one single-ported word RAM
// through a round-robin arbiter. Byte-strobed writes, fixed-latency reads routed
// back to the issuing channel, out-of-range accesses dropped or flagged.
//
// Handshake: a request transfers in a cycle where req_valid[i] and req_ready[i]
// are both high; ready is a pure function of valid (never the reverse), the
// requester holds its request stable until it transfers, and responses carry no
// backpressure (rsp_valid is a single-cycle pulse the requester must accept).
module soc_mem_mp_arb
    import soc_mem_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int MEM_DEPTH  = 64,
    parameter  int NUM_CH     = 2,
    parameter  int RD_LATENCY = 1,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH),
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            req_valid,
    output logic [NUM_CH-1:0]            req_ready,
    input  logic [NUM_CH-1:0]            req_we,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_CH*STRB_W-1:0]     req_wstrb,
    output logic [NUM_CH-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]        rsp_rdata,
    output logic                         rsp_err
);

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    logic [NUM_CH-1:0]     grant;
    ch_id_t                grant_id;
    logic                  accept;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [STRB_W-1:0]     sel_wstrb;
    logic                  in_range;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    rd_pipe_t              pipe [RD_LATENCY];

    soc_rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (req_valid),
        .advance  (accept),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // Nothing is accepted while reset is held, so no write or read slips through.
    assign req_ready = grant & {NUM_CH{~reset}};
    assign accept    = |req_ready;

    // Select the granted channel's request fields.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant[c]) begin
                sel_we    = req_we[c];
                sel_addr  = req_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[c*DATA_WIDTH +: DATA_WIDTH];
                sel_wstrb = req_wstrb[c*STRB_W +: STRB_W];
            end
        end
    end

    assign in_range = ({1'b0, sel_addr} < DEPTH_L);
    assign rd_word  = in_range ? mem[sel_addr] : '0;

    // RAM write with byte strobes; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept && sel_we && in_range) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (sel_wstrb[b]) begin
                    mem[sel_addr][b*8 +: 8] <= sel_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read pipe: stage 0 captures the read at the accepting edge, later stages delay it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            pipe[0] <= '{valid: accept & ~sel_we,
                         ch_id: grant_id,
                         data:  MAX_DATA_WIDTH'(rd_word),
                         err:   ~in_range};
            for (int k = 1; k < RD_LATENCY; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    // Route the last pipe stage to the issuing channel; bus is zero when idle.
    always_comb begin
        rsp_valid = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            rsp_valid[c] = pipe[RD_LATENCY-1].valid && (pipe[RD_LATENCY-1].ch_id == ch_id_t'(c));
        end
        rsp_rdata = pipe[RD_LATENCY-1].valid ? DATA_WIDTH'(pipe[RD_LATENCY-1].data) : '0;
        rsp_err   = pipe[RD_LATENCY-1].valid & pipe[RD_LATENCY-1].err;
    end

endmodule

// File: tb/tb_soc_mem_mp_arb.sv
// Directed bench for soc_mem_mp_arb: one 3-channel, 48-word instance for
// arbitration, strobes and range handling, plus four 2-channel instances
// (RD_LATENCY 1..4) for latency and reset-in-flight behaviour.
module tb_soc_mem_mp_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Instance A: NUM_CH=3, MEM_DEPTH=48, RD_LATENCY=1 (ADDR_WIDTH=6)
    logic [2:0]  a_valid, a_ready, a_we, a_rsp_valid;
    logic [17:0] a_addr;
    logic [95:0] a_wdata;
    logic [11:0] a_wstrb;
    logic [31:0] a_rdata;
    logic        a_err;

    soc_mem_mp_arb #(.DATA_WIDTH(32), .MEM_DEPTH(48), .NUM_CH(3), .RD_LATENCY(1)) u_dut_a (
        .clk       (clk),
        .reset     (rst),
        .req_valid (a_valid),
        .req_ready (a_ready),
        .req_we    (a_we),
        .req_addr  (a_addr),
        .req_wdata (a_wdata),
        .req_wstrb (a_wstrb),
        .rsp_valid (a_rsp_valid),
        .rsp_rdata (a_rdata),
        .rsp_err   (a_err)
    );

    // Latency instances: NUM_CH=2, MEM_DEPTH=64, RD_LATENCY=g
    logic [1:0]  l_valid     [1:4];
    logic [1:0]  l_ready     [1:4];
    logic [1:0]  l_we        [1:4];
    logic [11:0] l_addr      [1:4];
    logic [63:0] l_wdata     [1:4];
    logic [7:0]  l_wstrb     [1:4];
    logic [1:0]  l_rsp_valid [1:4];
    logic [31:0] l_rdata     [1:4];
    logic        l_err       [1:4];

    for (genvar g = 1; g <= 4; g++) begin : g_lat
        soc_mem_mp_arb #(.DATA_WIDTH(32), .MEM_DEPTH(64), .NUM_CH(2), .RD_LATENCY(g)) u_dut_l (
            .clk       (clk),
            .reset     (rst),
            .req_valid (l_valid[g]),
            .req_ready (l_ready[g]),
            .req_we    (l_we[g]),
            .req_addr  (l_addr[g]),
            .req_wdata (l_wdata[g]),
            .req_wstrb (l_wstrb[g]),
            .rsp_valid (l_rsp_valid[g]),
            .rsp_rdata (l_rdata[g]),
            .rsp_err   (l_err[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_set(input int ch, input logic we, input logic [5:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
        a_valid[ch]          = 1'b1;
        a_we[ch]             = we;
        a_addr[ch*6 +: 6]    = addr;
        a_wdata[ch*32 +: 32] = wdata;
        a_wstrb[ch*4 +: 4]   = strb;
    endtask

    task automatic l_set(input int g, input logic [1:0] valid, input logic we, input logic [5:0] addr,
                         input logic [31:0] wdata);
        l_valid[g]       = valid;
        l_we[g]          = {we, we};
        l_addr[g]        = {addr, addr};
        l_wdata[g]       = {wdata, wdata};
        l_wstrb[g]       = 8'hFF;
    endtask

    initial begin
        a_valid = '0; a_we = '0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
        for (int g = 1; g <= 4; g++) l_set(g, 2'b00, 1'b0, 6'd0, 32'd0);

        // 1: reset held 3 cycles with every request valid
        rst = 1'b1;
        a_valid = 3'b111;
        for (int g = 1; g <= 4; g++) l_valid[g] = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ready", 64'(a_ready), 64'd0);
            chk("rst_rsp_valid", 64'(a_rsp_valid), 64'd0);
            chk("rst_rdata", 64'(a_rdata), 64'd0);
            chk("rst_lat_ready", 64'(l_ready[3]), 64'd0);
        end
        a_valid = '0;
        for (int g = 1; g <= 4; g++) l_valid[g] = 2'b00;
        rst = 1'b0;
        tick();

        // 2: ch0 full write, byte-0 write, read-after-write
        a_set(0, 1'b1, 6'd5, 32'hDEADBEEF, 4'hF);
        #1 chk("t2_wr1_ready", 64'(a_ready), 64'b001);
        tick();
        a_set(0, 1'b1, 6'd5, 32'h000000AA, 4'h1);
        #1 chk("t2_wr2_ready", 64'(a_ready), 64'b001);
        tick();
        a_set(0, 1'b0, 6'd5, 32'd0, 4'h0);
        #1 chk("t2_rd_ready", 64'(a_ready), 64'b001);
        chk("t2_rsp_idle", 64'(a_rsp_valid), 64'd0);
        tick();
        a_valid = '0;
        #1 chk("t2_rsp_valid", 64'(a_rsp_valid), 64'b001);
        chk("t2_rdata", 64'(a_rdata), 64'hDEADBEAA);
        chk("t2_err", 64'(a_err), 64'd0);
        tick();
        chk("t2_rsp_pulse", 64'(a_rsp_valid), 64'd0);
        // bytes 3 and 1 replaced, bytes 2 and 0 kept
        a_set(0, 1'b1, 6'd5, 32'h11223344, 4'b1010);
        tick();
        a_set(0, 1'b0, 6'd5, 32'd0, 4'h0);
        tick();
        a_valid = '0;
        #1 chk("t2_strb_rdata", 64'(a_rdata), 64'h11AD33AA);

        // preload for fairness and range tests
        for (int i = 0; i < 3; i++) begin
            a_set(0, 1'b1, 6'(10 + i), 32'hA0 + i, 4'hF);
            tick();
        end
        a_set(0, 1'b1, 6'd47, 32'h47474747, 4'hF);
        tick();
        a_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // 3: all three channels read continuously -> 0,1,2,0,1,2
        for (int c = 0; c < 3; c++) a_set(c, 1'b0, 6'(10 + c), 32'd0, 4'h0);
        for (int k = 0; k < 6; k++) begin
            #1 chk("t3_grant", 64'(a_ready), 64'(1 << (k % 3)));
            if (k >= 1) begin
                chk("t3_rsp_route", 64'(a_rsp_valid), 64'(1 << ((k - 1) % 3)));
                chk("t3_rsp_data", 64'(a_rdata), 64'(32'hA0 + (k - 1) % 3));
            end
            tick();
        end
        a_valid = '0;
        #1 chk("t3_last_route", 64'(a_rsp_valid), 64'b100);
        chk("t3_last_data", 64'(a_rdata), 64'hA2);
        tick();

        // 4: out-of-range write dropped, read flagged; @47 untouched
        a_set(1, 1'b1, 6'd50, 32'h1234, 4'hF);
        #1 chk("t4_wr_ready", 64'(a_ready), 64'b010);
        tick();
        a_set(1, 1'b0, 6'd50, 32'd0, 4'h0);
        #1 chk("t4_rd_ready", 64'(a_ready), 64'b010);
        tick();
        a_set(1, 1'b0, 6'd47, 32'd0, 4'h0);
        #1 chk("t4_oor_valid", 64'(a_rsp_valid), 64'b010);
        chk("t4_oor_rdata", 64'(a_rdata), 64'd0);
        chk("t4_oor_err", 64'(a_err), 64'd1);
        tick();
        a_valid = '0;
        #1 chk("t4_47_valid", 64'(a_rsp_valid), 64'b010);
        chk("t4_47_rdata", 64'(a_rdata), 64'h47474747);
        chk("t4_47_err", 64'(a_err), 64'd0);
        tick();

        // 5: latency sweep, back-to-back reads @0..7 on ch0
        for (int i = 0; i < 8; i++) begin
            for (int g = 1; g <= 4; g++) l_set(g, 2'b01, 1'b1, 6'(i), 32'hC0DE0000 + i);
            tick();
        end
        for (int k = 0; k < 12; k++) begin
            for (int g = 1; g <= 4; g++) begin
                if (k < 8) l_set(g, 2'b01, 1'b0, 6'(k), 32'd0);
                else       l_set(g, 2'b00, 1'b0, 6'd0, 32'd0);
            end
            #1;
            for (int g = 1; g <= 4; g++) begin
                if (k < 8) chk($sformatf("t5_ready_l%0d", g), 64'(l_ready[g]), 64'b01);
                if (k >= g && k - g < 8) begin
                    chk($sformatf("t5_valid_l%0d", g), 64'(l_rsp_valid[g]), 64'b01);
                    chk($sformatf("t5_data_l%0d", g), 64'(l_rdata[g]), 64'(32'hC0DE0000 + k - g));
                end else begin
                    chk($sformatf("t5_idle_l%0d", g), 64'(l_rsp_valid[g]), 64'b00);
                end
            end
            tick();
        end

        // 6: reset while a read is in flight (RD_LATENCY=3)
        l_set(3, 2'b01, 1'b0, 6'd0, 32'd0);
        #1 chk("t6_accept", 64'(l_ready[3]), 64'b01);
        tick();
        l_set(3, 2'b00, 1'b0, 6'd0, 32'd0);
        rst = 1'b1;
        #1 chk("t6_rst_valid", 64'(l_rsp_valid[3]), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("t6_no_rsp", 64'(l_rsp_valid[3]), 64'd0);
            tick();
        end
        l_set(3, 2'b11, 1'b0, 6'd1, 32'd0);
        #1 chk("t6_ptr_reset", 64'(l_ready[3]), 64'b01);
        tick();
        l_set(3, 2'b00, 1'b0, 6'd0, 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
